// File: rtl/mha_pkg.sv
// Shared definitions for the fixed-point multiply/divide blocks (divider_16, multiplier_16).
package mha_pkg;

   // Default fractional width: Q2.13, so 16'h2000 represents 1.0
   localparam int FRAC_W_DEF = 13;

   // Symmetric saturation limits; 16'h8000 is never produced
   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8001;

   // Divider controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // One quotient bit per cycle over the 16 integer-aligned bits plus the fractional bits
   function automatic int iter_count(input int frac_w);
      return 16 + frac_w;
   endfunction

   // Iteration count at the default format (29)
   localparam int ITER_N_DEF = 16 + FRAC_W_DEF;

endpackage

// File: rtl/divider_16.sv
// Signed Q-format divider: sequential restoring division of operand magnitudes,
// one quotient bit per clock, with symmetric saturation and a divide-by-zero flag.
module divider_16
   import mha_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic        I_CLK,
   input  logic        I_RST,
   input  logic        I_VLD,
   input  logic [15:0] I_DIVIDEND,
   input  logic [15:0] I_DIVISOR,
   output logic        O_BUSY,
   output logic        O_VLD,
   output logic [15:0] O_QUOT,
   output logic        O_DZ
);

   localparam int N     = iter_count(FRAC_W);
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
   localparam logic [N-1:0]     POS_LIM  = {{(N-16){1'b0}}, SAT_POS};

   div_state_t       state;
   div_state_t       next_state;
   logic             accept;
   logic             last_iter;

   logic [CNT_W-1:0] cnt;
   logic [N-1:0]     dq;
   logic [15:0]      rem;
   logic [15:0]      mag_b;
   logic             q_sign;
   logic             dz;

   logic [15:0]      mag_a_in;
   logic [15:0]      mag_b_in;
   logic [16:0]      trial;
   logic             q_bit;
   logic [15:0]      next_rem;
   logic [N-1:0]     q_final;
   logic [15:0]      result;

   // State register; reset forces IDLE which aborts any division in flight
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic, acceptance strobe, last-iteration strobe and busy flag
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_iter  = 1'b0;
      O_BUSY     = (state != IDLE);
      case (state)
         IDLE: begin
            if (I_VLD) begin
               next_state = CALC;
               accept     = 1'b1;
            end
         end
         CALC: begin
            if (cnt == LAST_CNT) begin
               next_state = DONE;
               last_iter  = 1'b1;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operand magnitudes on 16 bits (0x8000 stays 0x8000) and one restoring step
   always_comb begin
      mag_a_in = I_DIVIDEND[15] ? (~I_DIVIDEND) + 16'd1 : I_DIVIDEND;
      mag_b_in = I_DIVISOR[15]  ? (~I_DIVISOR)  + 16'd1 : I_DIVISOR;
      trial    = {rem, dq[N-1]};
      q_bit    = (trial >= {1'b0, mag_b});
      next_rem = q_bit ? (trial[15:0] - mag_b) : trial[15:0];
      q_final  = {dq[N-2:0], q_bit};
   end

   // Apply sign, saturation and the divide-by-zero override to the final quotient
   always_comb begin
      result = 16'h0000;
      if (dz) begin
         result = q_sign ? SAT_NEG : SAT_POS;
      end else if (q_final > POS_LIM) begin
         result = q_sign ? SAT_NEG : SAT_POS;
      end else if (q_sign) begin
         result = (~q_final[15:0]) + 16'd1;
      end else begin
         result = q_final[15:0];
      end
   end

   // Datapath: capture operands on accept, iterate in CALC, publish result on the last step
   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         cnt    <= '0;
         dq     <= '0;
         rem    <= '0;
         mag_b  <= '0;
         q_sign <= 1'b0;
         dz     <= 1'b0;
         O_VLD  <= 1'b0;
         O_QUOT <= 16'h0000;
         O_DZ   <= 1'b0;
      end else begin
         O_VLD <= last_iter;
         if (accept) begin
            cnt    <= '0;
            dq     <= {mag_a_in, {FRAC_W{1'b0}}};
            rem    <= '0;
            mag_b  <= mag_b_in;
            q_sign <= I_DIVIDEND[15] ^ I_DIVISOR[15];
            dz     <= (I_DIVISOR == 16'h0000);
         end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
            dq  <= q_final;
            rem <= next_rem;
            if (last_iter) begin
               O_QUOT <= result;
               O_DZ   <= dz;
            end
         end
      end
   end

endmodule

// File: tb/tb_divider_16.sv
// Self-checking bench for divider_16: directed corner cases, randomized operands
// against an arithmetic reference model, back-to-back requests and mid-operation reset.
module tb_divider_16;

   logic        I_CLK;
   logic        I_RST;
   logic        I_VLD;
   logic [15:0] I_DIVIDEND;
   logic [15:0] I_DIVISOR;
   logic        O_BUSY;
   logic        O_VLD;
   logic [15:0] O_QUOT;
   logic        O_DZ;

   int check_count = 0;
   int fail_count  = 0;

   divider_16 dut (
      .I_CLK      (I_CLK),
      .I_RST      (I_RST),
      .I_VLD      (I_VLD),
      .I_DIVIDEND (I_DIVIDEND),
      .I_DIVISOR  (I_DIVISOR),
      .O_BUSY     (O_BUSY),
      .O_VLD      (O_VLD),
      .O_QUOT     (O_QUOT),
      .O_DZ       (O_DZ)
   );

   // Free-running 10 ns clock
   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   // Compare one observed value against its expected value and log a mismatch
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   // Reference model in plain integer arithmetic; returns {dz, quotient}
   function automatic logic [16:0] refDiv(input logic [15:0] a, input logic [15:0] b);
      longint sa;
      longint sb;
      longint ma;
      longint mb;
      longint qm;
      logic [15:0] q16;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
         return {1'b1, (sa < 0) ? 16'h8001 : 16'h7FFF};
      end
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      qm = (ma * 8192) / mb;
      if (qm > 32767) qm = 32767;
      if ((sa < 0) != (sb < 0)) qm = -qm;
      q16 = 16'(qm);
      return {1'b0, q16};
   endfunction

   // Issue one operation from IDLE and check latency, result, flags and the busy window
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] exp_q, input logic exp_dz, input string tag);
      int k;
      checkOutput({tag, ".idle_busy"}, 32'(O_BUSY), 32'd0);
      I_DIVIDEND = a;
      I_DIVISOR  = b;
      I_VLD      = 1'b1;
      @(posedge I_CLK);
      #1;
      I_VLD = 1'b0;
      checkOutput({tag, ".busy_e0"}, 32'(O_BUSY), 32'd1);
      k = 0;
      while (k < 40) begin
         @(posedge I_CLK);
         #1;
         k++;
         if (O_VLD) break;
      end
      checkOutput({tag, ".latency"}, 32'(k), 32'd29);
      checkOutput({tag, ".quot"}, 32'(O_QUOT), 32'(exp_q));
      checkOutput({tag, ".dz"}, 32'(O_DZ), 32'(exp_dz));
      checkOutput({tag, ".busy_en"}, 32'(O_BUSY), 32'd1);
      @(posedge I_CLK);
      #1;
      checkOutput({tag, ".vld_drop"}, 32'(O_VLD), 32'd0);
      checkOutput({tag, ".busy_drop"}, 32'(O_BUSY), 32'd0);
      checkOutput({tag, ".quot_hold"}, 32'(O_QUOT), 32'(exp_q));
   endtask

   initial begin
      logic [16:0] exp_r;
      logic [15:0] ra;
      logic [15:0] rb;
      int next_acc;
      int due;

      I_RST      = 1'b1;
      I_VLD      = 1'b0;
      I_DIVIDEND = 16'h0000;
      I_DIVISOR  = 16'h0000;
      repeat (2) @(posedge I_CLK);
      #1;
      checkOutput("reset.busy", 32'(O_BUSY), 32'd0);
      checkOutput("reset.vld", 32'(O_VLD), 32'd0);
      checkOutput("reset.quot", 32'(O_QUOT), 32'd0);
      checkOutput("reset.dz", 32'(O_DZ), 32'd0);
      I_RST = 1'b0;

      // Directed corner cases with hand-derived expectations
      applyStimulus(16'h2000, 16'h4000, 16'h1000, 1'b0, "one_by_two");
      applyStimulus(16'hD000, 16'h1000, 16'hA000, 1'b0, "neg_by_half");
      applyStimulus(16'h6000, 16'h0800, 16'h7FFF, 1'b0, "sat_pos");
      applyStimulus(16'h8000, 16'h2000, 16'h8001, 1'b0, "sat_neg");
      applyStimulus(16'hE000, 16'h0000, 16'h8001, 1'b1, "dz_neg");
      applyStimulus(16'h0000, 16'h0000, 16'h7FFF, 1'b1, "dz_zero");
      applyStimulus(16'h0000, 16'hE000, 16'h0000, 1'b0, "signed_zero");
      applyStimulus(16'h0001, 16'h7FFF, 16'h0000, 1'b0, "trunc_tiny");

      // Randomized operands against the reference model
      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 5 == 0) rb = 16'($urandom_range(0, 3));
         if (i % 7 == 3) rb = 16'h8000;
         exp_r = refDiv(ra, rb);
         applyStimulus(ra, rb, exp_r[15:0], exp_r[16], "random");
      end

      // I_VLD held high with operands changing every cycle: only IDLE samples count
      next_acc = 0;
      due      = -1;
      exp_r    = '0;
      for (int e = 0; e < 123; e++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         I_DIVIDEND = ra;
         I_DIVISOR  = rb;
         I_VLD      = 1'b1;
         @(posedge I_CLK);
         #1;
         if (e == next_acc) begin
            exp_r    = refDiv(ra, rb);
            due      = e + 29;
            next_acc = e + 31;
         end
         checkOutput("stream.vld", 32'(O_VLD), 32'(e == due));
         if (e == due) begin
            checkOutput("stream.quot", 32'(O_QUOT), 32'(exp_r[15:0]));
            checkOutput("stream.dz", 32'(O_DZ), 32'(exp_r[16]));
         end
      end
      I_VLD = 1'b0;
      @(posedge I_CLK);
      #1;
      checkOutput("stream.idle", 32'(O_BUSY), 32'd0);

      // Reset pulsed at iteration 10 aborts the operation and clears outputs
      I_DIVIDEND = 16'h3000;
      I_DIVISOR  = 16'h1000;
      I_VLD      = 1'b1;
      @(posedge I_CLK);
      #1;
      I_VLD = 1'b0;
      repeat (10) @(posedge I_CLK);
      #3;
      I_RST = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(O_BUSY), 32'd0);
      checkOutput("abort.vld", 32'(O_VLD), 32'd0);
      checkOutput("abort.quot", 32'(O_QUOT), 32'd0);
      checkOutput("abort.dz", 32'(O_DZ), 32'd0);
      @(posedge I_CLK);
      #1;
      checkOutput("abort.hold_busy", 32'(O_BUSY), 32'd0);
      I_RST = 1'b0;
      applyStimulus(16'h2000, 16'h2000, 16'h2000, 1'b0, "after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
